// File: rtl/avalon_image_writer.sv
// Avalon-MM write master: buffers packed pixel words in a small FIFO and streams them to memory at buff.
// Optional abort-on-start-drop behaviour is enabled by defining AVALON_IMAGE_WRITER_ABORT_EN.
module avalon_image_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_capture,
  input  logic [23:0]       capture_imgsize,
  input  logic [31:0]       buff,
  output logic              image_captured,
  output logic              capture_standby,
  input  logic              pix_valid,
  input  logic [31:0]       pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] avm_m1_address,
  output logic              avm_m1_write,
  output logic [31:0]       avm_m1_writedata,
  output logic [3:0]        avm_m1_byteenable,
  input  logic              avm_m1_waitrequest
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

  state_t            state_reg;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;
  logic [21:0]       total_words_reg, accepted_reg, written_reg;
  logic [21:0]       accepted_next, written_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              start_prev_reg;
  logic              start_event, complete, push, pop, abort_req;
  logic [1:0]        unused_imgsize_lsbs;

  assign unused_imgsize_lsbs = capture_imgsize[1:0];
  assign avm_m1_byteenable   = 4'hF;

  always_comb begin
    start_event   = start_capture & ~start_prev_reg;
    complete      = avm_m1_write & ~avm_m1_waitrequest;
    push          = pix_valid & pix_ready;
`ifdef AVALON_IMAGE_WRITER_ABORT_EN
    abort_req     = (state_reg == RUN) && !start_capture;
`else
    abort_req     = 1'b0;
`endif
    // A new word may be loaded whenever the bus register is free or is being emptied this cycle.
    pop           = (state_reg == RUN) && (count_reg != '0) && (!avm_m1_write || complete) && !abort_req;
    count_next    = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    accepted_next = accepted_reg + 22'(push);
    written_next  = written_reg + 22'(complete);
    addr_next     = complete ? addr_reg + ADDR_W'(4) : addr_reg;
  end

  // Storage has no reset so it can map onto RAM; occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= pix_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      start_prev_reg   <= 1'b1;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      total_words_reg  <= '0;
      accepted_reg     <= '0;
      written_reg      <= '0;
      addr_reg         <= '0;
      capture_standby  <= 1'b1;
      image_captured   <= 1'b0;
      pix_ready        <= 1'b0;
      avm_m1_write     <= 1'b0;
      avm_m1_address   <= '0;
      avm_m1_writedata <= '0;
    end else begin
      start_prev_reg <= start_capture;
      image_captured <= 1'b0;
      count_reg      <= count_next;
      accepted_reg   <= accepted_next;
      written_reg    <= written_next;
      addr_reg       <= addr_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg       <= rd_ptr_reg + PTR_W'(1);
        avm_m1_writedata <= fifo_mem[rd_ptr_reg];
        avm_m1_address   <= addr_next;
        avm_m1_write     <= 1'b1;
      end else if (complete) begin
        avm_m1_write <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          pix_ready <= 1'b0;
          if (start_event) begin
            state_reg       <= RUN;
            total_words_reg <= capture_imgsize[23:2];
            addr_reg        <= ADDR_W'(buff);
            accepted_reg    <= '0;
            written_reg     <= '0;
            capture_standby <= 1'b0;
            pix_ready       <= (capture_imgsize[23:2] != '0);
          end
        end
        RUN: begin
          if (written_next == total_words_reg) begin
            state_reg      <= DONE;
            image_captured <= 1'b1;
            pix_ready      <= 1'b0;
          end else if (abort_req) begin
            state_reg <= ABORT;
            pix_ready <= 1'b0;
          end else begin
            pix_ready <= (count_next < DEPTH_CNT) && (accepted_next < total_words_reg);
          end
        end
        DONE: begin
          state_reg       <= IDLE;
          capture_standby <= 1'b1;
        end
        ABORT: begin
          pix_ready <= 1'b0;
          // Let the in-flight write finish, then discard whatever is still buffered.
          if (!avm_m1_write || complete) begin
            state_reg       <= IDLE;
            capture_standby <= 1'b1;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_image_writer.sv
// Self-checking bench for avalon_image_writer: randomized pixel/stall traffic against a queue-based memory-write model.
module tb_avalon_image_writer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_capture = 1'b0;
  logic [23:0] capture_imgsize = '0;
  logic [31:0] buff = '0;
  logic        image_captured;
  logic        capture_standby;
  logic        pix_valid = 1'b0;
  logic [31:0] pix_data = '0;
  logic        pix_ready;
  logic [31:0] avm_m1_address;
  logic        avm_m1_write;
  logic [31:0] avm_m1_writedata;
  logic [3:0]  avm_m1_byteenable;
  logic        avm_m1_waitrequest = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  avalon_image_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start_capture      (start_capture),
    .capture_imgsize    (capture_imgsize),
    .buff               (buff),
    .image_captured     (image_captured),
    .capture_standby    (capture_standby),
    .pix_valid          (pix_valid),
    .pix_data           (pix_data),
    .pix_ready          (pix_ready),
    .avm_m1_address     (avm_m1_address),
    .avm_m1_write       (avm_m1_write),
    .avm_m1_writedata   (avm_m1_writedata),
    .avm_m1_byteenable  (avm_m1_byteenable),
    .avm_m1_waitrequest (avm_m1_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One capture: memory must receive the accepted pixels in order at b, b+4, ... (mod 2^32).
  task automatic do_capture(input logic [31:0] b, input logic [23:0] sz, input int valid_pct,
                            input int wait_pct, input int first_stall,
                            output int acc_at_release, output int ready_at_release,
                            output int first_span, output int wr_span);
    logic [31:0] exp_data[$];
    logic [31:0] exp_addr, held_addr, held_data;
    logic        held;
    bit          span_done;
    int n_words, n_acc, n_wr, pulses, pulse_cyc, first_wr_cyc, last_wr_cyc, start_cyc, stall_left;
    n_words = int'(sz >> 2);
    n_acc = 0; n_wr = 0; pulses = 0; pulse_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    stall_left = first_stall; held = 1'b0; span_done = 1'b0;
    held_addr = '0; held_data = '0;
    acc_at_release = -1; ready_at_release = -1; first_span = 0; wr_span = -1;
    @(negedge clk);
    buff = b; capture_imgsize = sz; start_capture = 1'b1; pix_valid = 1'b0; avm_m1_waitrequest = 1'b0;
    start_cyc = cyc;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("standby_low_after_start", capture_standby, 1'b0);
        buff = $urandom;
        capture_imgsize = 24'($urandom);
      end
      if (image_captured) begin
        pulses++;
        if (pulse_cyc < 0) pulse_cyc = cyc;
      end
      if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) chk("standby_after_pulse", capture_standby, 1'b1);
      if (held) begin
        chk("hold_write", avm_m1_write, 1'b1);
        chk("hold_addr", avm_m1_address, held_addr);
        chk("hold_data", avm_m1_writedata, held_data);
      end
      if (avm_m1_write && stall_left > 0) begin
        avm_m1_waitrequest = 1'b1;
        stall_left--;
      end else begin
        if (first_stall > 0 && acc_at_release < 0 && stall_left == 0) begin
          acc_at_release = n_acc;
          ready_at_release = int'(pix_ready);
        end
        avm_m1_waitrequest = ($urandom_range(0, 99) < wait_pct);
      end
      pix_valid = ($urandom_range(0, 99) < valid_pct);
      pix_data = $urandom;
      if (pix_valid && pix_ready) begin
        exp_data.push_back(pix_data);
        n_acc++;
      end
      if (avm_m1_write && !span_done) first_span++;
      if (avm_m1_write && !avm_m1_waitrequest) begin
        span_done = 1'b1;
        exp_addr = b + 32'(4 * n_wr);
        chk("wr_addr", avm_m1_address, exp_addr);
        if (n_wr < exp_data.size()) chk("wr_data", avm_m1_writedata, exp_data[n_wr]);
        else chk("wr_without_pixel", n_wr, exp_data.size());
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        n_wr++;
      end
      held = avm_m1_write && avm_m1_waitrequest;
      held_addr = avm_m1_address;
      held_data = avm_m1_writedata;
      if (pulse_cyc >= 0 && cyc >= pulse_cyc + 2) break;
    end
    pix_valid = 1'b0; avm_m1_waitrequest = 1'b0; start_capture = 1'b0;
    wr_span = last_wr_cyc - first_wr_cyc;
    chk("pulse_count", pulses, 1);
    chk("accepted_words", n_acc, n_words);
    chk("written_words", n_wr, n_words);
    if (n_words > 0) chk("pulse_after_last_write", pulse_cyc, last_wr_cyc + 1);
    else chk("pulse_zero_size", pulse_cyc, start_cyc + 2);
    $display("capture buff=0x%08h size=%0d words=%0d writes=%0d accepted=%0d", b, sz, n_words, n_wr, n_acc);
  endtask

  initial begin
    int acc, rdy, span, wspan, n, extra, pulses;
    logic [31:0] rb;
    logic [23:0] rs;

    repeat (3) @(negedge clk);
    chk("rst_standby", capture_standby, 1'b1);
    chk("rst_captured", image_captured, 1'b0);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_write", avm_m1_write, 1'b0);
    chk("rst_address", avm_m1_address, 32'h0);
    chk("rst_writedata", avm_m1_writedata, 32'h0);
    chk("rst_byteenable", avm_m1_byteenable, 4'hF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    do_capture(32'h0000_1000, 24'd16, 100, 0, 0, acc, rdy, span, wspan);
    chk("t1_back_to_back_span", wspan, 3);

    do_capture(32'h0000_2000, 24'd8, 100, 0, 3, acc, rdy, span, wspan);
    chk("t2_first_write_cycles", span, 4);

    // While stalled, the FIFO fills and one more word sits in the write-data register.
    do_capture(32'h0000_3000, 24'(4 * (DEPTH + 4)), 100, 0, 40, acc, rdy, span, wspan);
    chk("t3_accepted_while_stalled", acc, DEPTH + 1);
    chk("t3_ready_low_when_full", rdy, 0);

    do_capture(32'h0000_4000, 24'd2, 100, 0, 0, acc, rdy, span, wspan);
    do_capture(32'hFFFF_FFF8, 24'd16, 100, 0, 0, acc, rdy, span, wspan);

    for (int i = 0; i < 8; i++) begin
      rb = $urandom;
      rs = 24'($urandom_range(0, 40) * 4 + $urandom_range(0, 3));
      do_capture(rb, rs, 60, 30, 0, acc, rdy, span, wspan);
    end

    // Reset in the middle of a stalled write, with start held high across reset.
    @(negedge clk);
    buff = 32'h0000_5000; capture_imgsize = 24'd64; start_capture = 1'b1;
    pix_valid = 1'b1; avm_m1_waitrequest = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_precond_write", avm_m1_write, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_async_write_drop", avm_m1_write, 1'b0);
    chk("midrst_standby", capture_standby, 1'b1);
    chk("midrst_pix_ready", pix_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (image_captured || avm_m1_write || !capture_standby) pulses++;
    end
    chk("held_start_no_event", pulses, 0);
    $display("midrst: capture abandoned, held start ignored");
    start_capture = 1'b0; pix_valid = 1'b0; avm_m1_waitrequest = 1'b0;

`ifdef AVALON_IMAGE_WRITER_ABORT_EN
    @(negedge clk);
    buff = 32'h0000_6000; capture_imgsize = 24'd64; start_capture = 1'b1;
    pix_valid = 1'b1; avm_m1_waitrequest = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (avm_m1_write) begin
        if (n == 3) break;
        n++;
      end
    end
    chk("abort_precond_writes", n, 3);
    chk("abort_precond_write", avm_m1_write, 1'b1);
    chk("abort_pending_addr", avm_m1_address, 32'h0000_600C);
    avm_m1_waitrequest = 1'b1; start_capture = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_hold_write", avm_m1_write, 1'b1);
    end
    avm_m1_waitrequest = 1'b0;
    extra = int'(avm_m1_write);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (avm_m1_write) extra++;
      if (image_captured) pulses++;
    end
    chk("abort_extra_writes", extra, 1);
    chk("abort_no_pulse", pulses, 0);
    chk("abort_standby", capture_standby, 1'b1);
    chk("abort_pix_ready", pix_ready, 1'b0);
    $display("abort: extra_writes=%0d pulses=%0d", extra, pulses);
    pix_valid = 1'b0;
    do_capture(32'h0000_6000, 24'd16, 100, 0, 0, acc, rdy, span, wspan);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
